seg_scan8: RTL and testbench



---
 rtl/seg_scan8.sv | 124 ++++++++++++
 tb/tb_seg_scan8.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scan8.sv
// Multiplexed 8-digit 7-segment scanner: snapshots a 32-bit nibble word once per
// frame, steps one digit per prescaler tick, and hex-decodes with optional blanking.
module seg_scan8 #(
  parameter int unsigned DIV    = 50000,
  parameter bit          SEG_AL = 1'b1,
  parameter bit          AN_AL  = 1'b1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] data,
  input  logic [3:0]  valid_cnt,
  input  logic        blank_en,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [7:0]  an,
  output logic [2:0]  digit_idx,
  output logic        frame
);

  localparam logic [19:0] CNT_MAX = 20'(DIV - 1);
  localparam logic [6:0]  SEG_OFF = SEG_AL ? 7'h7F : 7'h00;
  localparam logic [7:0]  AN_OFF  = AN_AL ? 8'hFF : 8'h00;
  localparam logic        DP_OFF  = SEG_AL;

  // Active-high glyph, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

  function automatic logic [3:0] sat_cnt(input logic [3:0] v);
    return (v > 4'd8) ? 4'd8 : v;
  endfunction

  logic [19:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] shadow_q, shadow_d;
  logic [3:0]  shcnt_q, shcnt_d;
  logic        frame_q, frame_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic [7:0]  an_q, an_d;

  logic        tick;
  logic        wrap;
  logic        blank;
  logic [3:0]  nib;
  logic [6:0]  seg_on;
  logic [7:0]  an_on;
  logic        dp_on;

  always_comb begin
    tick     = (cnt_q == CNT_MAX);
    wrap     = tick && (idx_q == 3'd7);
    cnt_d    = tick ? 20'd0 : cnt_q + 20'd1;
    idx_d    = tick ? idx_q + 3'd1 : idx_q;
    shadow_d = wrap ? data : shadow_q;
    shcnt_d  = wrap ? sat_cnt(valid_cnt) : shcnt_q;
    frame_d  = wrap;

    // Decode from the next-state shadow so the wrap edge shows freshly captured data.
    nib    = shadow_d[{idx_d, 2'b00} +: 4];
    blank  = blank_en && ({1'b0, idx_d} >= shcnt_d);
    seg_on = blank ? 7'h00 : hex7(nib);
    an_on  = 8'd1 << idx_d;
    dp_on  = (idx_d == 3'd0) && (shcnt_d == 4'd8);

    seg_d = seg_q;
    an_d  = an_q;
    dp_d  = dp_q;
    if (tick) begin
      seg_d = SEG_AL ? ~seg_on : seg_on;
      an_d  = AN_AL ? ~an_on : an_on;
      dp_d  = dp_on ^ SEG_AL;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt_q    <= 20'd0;
      idx_q    <= 3'd7;
      shadow_q <= 32'd0;
      shcnt_q  <= 4'd0;
      frame_q  <= 1'b0;
      seg_q    <= SEG_OFF;
      an_q     <= AN_OFF;
      dp_q     <= DP_OFF;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      shcnt_q  <= shcnt_d;
      frame_q  <= frame_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      dp_q     <= dp_d;
    end
  end

  assign seg       = seg_q;
  assign dp        = dp_q;
  assign an        = an_q;
  assign digit_idx = idx_q;
  assign frame     = frame_q;

endmodule

// File: tb/tb_seg_scan8.sv
// Bench for seg_scan8: two instances (DIV=4 and DIV=1) checked every cycle against a
// time-based model, plus directed literal checks on key scan points.
module tb_seg_scan8;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] data;
  logic [3:0]  valid_cnt;
  logic        blank_en;

  logic [6:0] seg4, seg1;
  logic       dp4, dp1;
  logic [7:0] an4, an1;
  logic [2:0] idx4, idx1;
  logic       frame4, frame1;

  int npass = 0;
  int ntotal = 0;

  always #5 clk = ~clk;

  seg_scan8 #(.DIV(4), .SEG_AL(1'b1), .AN_AL(1'b1)) u_dut4 (
    .clk(clk), .clr(clr), .data(data), .valid_cnt(valid_cnt), .blank_en(blank_en),
    .seg(seg4), .dp(dp4), .an(an4), .digit_idx(idx4), .frame(frame4)
  );

  seg_scan8 #(.DIV(1), .SEG_AL(1'b1), .AN_AL(1'b1)) u_dut1 (
    .clk(clk), .clr(clr), .data(data), .valid_cnt(valid_cnt), .blank_en(blank_en),
    .seg(seg1), .dp(dp1), .an(an1), .digit_idx(idx1), .frame(frame1)
  );

  // Glyphs as lit-segment letter lists.
  string glyphs [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                         "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [6:0] glyph_mask(input logic [3:0] nib);
    logic [6:0] m;
    string s;
    m = 7'd0;
    s = glyphs[nib];
    for (int c = 0; c < s.len(); c++) m[s[c] - "a"] = 1'b1;
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    ntotal++;
    if (got === exp) npass++;
    else $display("FAIL %s got %0h want %0h", name, got, exp);
  endtask

  // Model: a tick lands on every DIV-th clock after release; tick n shows digit (n-1) mod 8.
  int         cyc   [2];
  logic [31:0] snap [2];
  int         scnt  [2];
  logic [6:0] e_seg [2];
  logic [7:0] e_an  [2];
  logic       e_dp  [2];
  logic [2:0] e_idx [2];
  logic       e_frm [2];

  always @(posedge clk or negedge clr) begin
    for (int i = 0; i < 2; i++) begin
      int d, k;
      d = (i == 0) ? 4 : 1;
      if (!clr) begin
        cyc[i] = 0; snap[i] = 32'd0; scnt[i] = 0;
        e_seg[i] = 7'h7F; e_an[i] = 8'hFF; e_dp[i] = 1'b1; e_idx[i] = 3'd7; e_frm[i] = 1'b0;
      end else begin
        cyc[i]++;
        e_frm[i] = 1'b0;
        if (cyc[i] % d == 0) begin
          k = ((cyc[i] / d) - 1) % 8;
          if (k == 0) begin
            snap[i]  = data;
            scnt[i]  = (valid_cnt > 4'd8) ? 8 : int'(valid_cnt);
            e_frm[i] = 1'b1;
          end
          e_idx[i] = 3'(k);
          e_an[i]  = ~(8'd1 << k);
          e_seg[i] = (blank_en && k >= scnt[i]) ? 7'h7F : ~glyph_mask(snap[i][4*k +: 4]);
          e_dp[i]  = !(k == 0 && scnt[i] == 8);
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("seg4", 32'(seg4), 32'(e_seg[0]));
    chk("an4", 32'(an4), 32'(e_an[0]));
    chk("dp4", 32'(dp4), 32'(e_dp[0]));
    chk("idx4", 32'(idx4), 32'(e_idx[0]));
    chk("frame4", 32'(frame4), 32'(e_frm[0]));
    chk("seg1", 32'(seg1), 32'(e_seg[1]));
    chk("an1", 32'(an1), 32'(e_an[1]));
    chk("dp1", 32'(dp1), 32'(e_dp[1]));
    chk("idx1", 32'(idx1), 32'(e_idx[1]));
    chk("frame1", 32'(frame1), 32'(e_frm[1]));
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    clr = 1'b1;
    data = 32'h76543210;
    valid_cnt = 4'd8;
    blank_en = 1'b0;
    #2 clr = 1'b0;
    cycles(2);
    chk("rst_an", 32'(an4), 32'hFF);
    chk("rst_seg", 32'(seg4), 32'h7F);
    chk("rst_dp", 32'(dp4), 32'h1);
    chk("rst_idx", 32'(idx4), 32'h7);
    chk("rst_frame", 32'(frame4), 32'h0);
    clr = 1'b1;

    cycles(3);
    chk("pre_tick_an", 32'(an4), 32'hFF);
    cycles(1);                                   // cycle 4: first tick
    chk("t4_frame", 32'(frame4), 32'h1);
    chk("t4_idx", 32'(idx4), 32'h0);
    chk("t4_an", 32'(an4), 32'hFE);
    chk("t4_seg", 32'(seg4), 32'h40);
    chk("t4_dp", 32'(dp4), 32'h0);
    cycles(1);
    chk("t5_frame", 32'(frame4), 32'h0);
    cycles(27);                                  // cycle 32: digit 7
    chk("t32_idx", 32'(idx4), 32'h7);
    chk("t32_an", 32'(an4), 32'h7F);
    chk("t32_seg", 32'(seg4), 32'h78);

    cycles(16);                                  // cycle 48: digit 3 of second frame
    data = 32'hFFFFFFFF;
    cycles(16);                                  // cycle 64: digit 7, still old snapshot
    chk("mid_old7", 32'(seg4), 32'h78);
    cycles(4);                                   // cycle 68: new frame shows F
    chk("mid_frame", 32'(frame4), 32'h1);
    chk("mid_newF", 32'(seg4), 32'h0E);

    blank_en = 1'b1;
    valid_cnt = 4'd3;
    data = 32'h00000ABC;
    cycles(32);                                  // cycle 100: digit 0 shows C
    chk("blk_d0", 32'(seg4), 32'h46);
    chk("blk_dp", 32'(dp4), 32'h1);
    cycles(4);                                   // digit 1 shows b
    chk("blk_d1", 32'(seg4), 32'h03);
    cycles(8);                                   // digit 3 blanked, an active
    chk("blk_d3_seg", 32'(seg4), 32'h7F);
    chk("blk_d3_an", 32'(an4), 32'hF7);

    valid_cnt = 4'hF;
    cycles(20);                                  // cycle 132: saturated count
    chk("sat_frame", 32'(frame4), 32'h1);
    chk("sat_dp", 32'(dp4), 32'h0);
    chk("sat_d0", 32'(seg4), 32'h46);
    cycles(12);                                  // digit 3 now shows 0
    chk("sat_d3", 32'(seg4), 32'h40);

    cycles(8);                                   // cycle 152: digit 5
    chk("pre_ar_idx", 32'(idx4), 32'h5);
    #2 clr = 1'b0;
    #1;
    chk("ar_an4", 32'(an4), 32'hFF);
    chk("ar_seg4", 32'(seg4), 32'h7F);
    chk("ar_dp4", 32'(dp4), 32'h1);
    chk("ar_idx4", 32'(idx4), 32'h7);
    chk("ar_an1", 32'(an1), 32'hFF);
    #2 clr = 1'b1;

    cycles(1);
    chk("d1_frame", 32'(frame1), 32'h1);
    chk("d1_idx", 32'(idx1), 32'h0);
    chk("d1_seg", 32'(seg1), 32'h46);
    chk("ar_wait_an4", 32'(an4), 32'hFF);
    cycles(3);
    chk("ar_frame4", 32'(frame4), 32'h1);
    chk("ar_resume_an4", 32'(an4), 32'hFE);
    chk("ar_resume_seg4", 32'(seg4), 32'h46);
    chk("d1_c4_idx", 32'(idx1), 32'h3);
    chk("d1_c4_frame", 32'(frame1), 32'h0);
    cycles(5);
    chk("d1_c9_frame", 32'(frame1), 32'h1);
    chk("d1_c9_idx", 32'(idx1), 32'h0);

    cycles(40);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
